disparity_search_ctrl: RTL and testbench

// Sequences the shared SAD array across one buffered image row (WIN rows deep): steps col_index over every

---
 rtl/disparity_search_ctrl_if.sv | 38 +++
 rtl/disparity_search_ctrl.sv | 154 +++++++++++++++
 tb/tb_disparity_search_ctrl.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/disparity_search_ctrl_if.sv
// Handshake/bus bundle between the disparity search controller and its environment
// (start/abort control, SAD array drive and feedback, disparity result stream).
// slave = the controller; master = the host / SAD array / map writer side.
interface disparity_search_ctrl_if #(
    parameter int WIN          = 7,
    parameter int DATA_SIZE    = 8,
    parameter int IMG_W        = 64,
    parameter int MAX_DISP     = 32,
    parameter int DISP_THREADS = 8
);
    localparam int G        = MAX_DISP / DISP_THREADS;
    localparam int SAD_BITS = $clog2(WIN * WIN * ((1 << DATA_SIZE) - 1) + 1);
    localparam int COL_W    = $clog2(IMG_W);
    localparam int GRP_W    = (G > 1) ? $clog2(G) : 1;
    localparam int DISP_W   = $clog2(MAX_DISP);

    logic                             start;
    logic                             abort;
    logic [DISP_THREADS*SAD_BITS-1:0] sad_val;
    logic [COL_W-1:0]                 col_index;
    logic [GRP_W-1:0]                 group_idx;
    logic                             busy;
    logic                             disp_valid;
    logic                             disp_ready;
    logic [DISP_W-1:0]                disp_out;
    logic [SAD_BITS-1:0]              disp_cost;
    logic                             row_done;

    modport master (
        output start, abort, sad_val, disp_ready,
        input  col_index, group_idx, busy, disp_valid, disp_out, disp_cost, row_done
    );

    modport slave (
        input  start, abort, sad_val, disp_ready,
        output col_index, group_idx, busy, disp_valid, disp_out, disp_cost, row_done
    );
endinterface

// File: rtl/disparity_search_ctrl.sv
// Sequences the shared SAD array over one row: every valid column x every candidate group, min-reduced.
// Latency: k*(SAD_LAT+1) cycles from column start to disp_valid, k = groups evaluated (early exit on SAD 0).
// Backpressure: result held in OUTPUT while disp_ready is low; disp_valid is registered, no ready->valid path.
// Ports: clk, rst (async, active-high); bus (slave modport): start/abort, sad_val in, col_index/group_idx
// out to the SAD array, busy, disp_valid/disp_ready/disp_out/disp_cost stream, row_done pulse.
module disparity_search_ctrl #(
    parameter int WIN          = 7,
    parameter int DATA_SIZE    = 8,
    parameter int IMG_W        = 64,
    parameter int MAX_DISP     = 32,
    parameter int DISP_THREADS = 8,
    parameter int SAD_LAT      = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    disparity_search_ctrl_if.slave    bus
);
    localparam int G        = MAX_DISP / DISP_THREADS;
    localparam int NUM_COLS = IMG_W - WIN - MAX_DISP + 2;
    localparam int SAD_BITS = $clog2(WIN * WIN * ((1 << DATA_SIZE) - 1) + 1);
    localparam int COL_W    = $clog2(IMG_W);
    localparam int GRP_W    = (G > 1) ? $clog2(G) : 1;
    localparam int DISP_W   = $clog2(MAX_DISP);
    localparam int CNT_W    = (SAD_LAT > 1) ? $clog2(SAD_LAT) : 1;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SETTLE = 2'd1;
    localparam logic [1:0] S_REDUCE = 2'd2;
    localparam logic [1:0] S_OUTPUT = 2'd3;

    logic [1:0]          state;
    logic [CNT_W-1:0]    settle_cnt;
    logic [COL_W-1:0]    col_q;
    logic [GRP_W-1:0]    grp_q;
    logic [SAD_BITS-1:0] best_sad;
    logic [DISP_W-1:0]   best_disp;
    logic                busy_q;
    logic                valid_q;
    logic                row_done_q;
    logic [DISP_W-1:0]   disp_out_q;
    logic [SAD_BITS-1:0] disp_cost_q;

    // Group reduction: strict compare while scanning upward, so the lowest lane wins ties.
    logic [SAD_BITS-1:0] grp_min;
    logic [DISP_W-1:0]   grp_min_disp;
    always_comb begin
        grp_min      = bus.sad_val[SAD_BITS-1:0];
        grp_min_disp = DISP_W'(int'(grp_q) * DISP_THREADS);
        for (int d = 1; d < DISP_THREADS; d++) begin
            if (bus.sad_val[SAD_BITS*d +: SAD_BITS] < grp_min) begin
                grp_min      = bus.sad_val[SAD_BITS*d +: SAD_BITS];
                grp_min_disp = DISP_W'(int'(grp_q) * DISP_THREADS + d);
            end
        end
    end

    // Strict cross-group compare keeps the earlier (lower) disparity on ties.
    logic                update;
    logic [SAD_BITS-1:0] new_best;
    logic [DISP_W-1:0]   new_best_disp;
    assign update        = (grp_min < best_sad);
    assign new_best      = update ? grp_min : best_sad;
    assign new_best_disp = update ? grp_min_disp : best_disp;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            settle_cnt  <= '0;
            col_q       <= '0;
            grp_q       <= '0;
            best_sad    <= '1;
            best_disp   <= '0;
            busy_q      <= 1'b0;
            valid_q     <= 1'b0;
            row_done_q  <= 1'b0;
            disp_out_q  <= '0;
            disp_cost_q <= '0;
        end else begin
            row_done_q <= 1'b0;
            if (bus.abort && state != S_IDLE) begin
                state      <= S_IDLE;
                settle_cnt <= '0;
                col_q      <= '0;
                grp_q      <= '0;
                best_sad   <= '1;
                best_disp  <= '0;
                busy_q     <= 1'b0;
                valid_q    <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (bus.start) begin
                            state      <= S_SETTLE;
                            settle_cnt <= '0;
                            col_q      <= '0;
                            grp_q      <= '0;
                            best_sad   <= '1;
                            best_disp  <= '0;
                            busy_q     <= 1'b1;
                        end
                    end
                    S_SETTLE: begin
                        // Wait out the SAD array pipeline for the current col/group.
                        if (settle_cnt == CNT_W'(SAD_LAT - 1)) begin
                            settle_cnt <= '0;
                            state      <= S_REDUCE;
                        end else begin
                            settle_cnt <= settle_cnt + 1'b1;
                        end
                    end
                    S_REDUCE: begin
                        best_sad  <= new_best;
                        best_disp <= new_best_disp;
                        if (new_best == '0 || grp_q == GRP_W'(G - 1)) begin
                            state       <= S_OUTPUT;
                            valid_q     <= 1'b1;
                            disp_out_q  <= new_best_disp;
                            disp_cost_q <= new_best;
                        end else begin
                            grp_q <= grp_q + 1'b1;
                            state <= S_SETTLE;
                        end
                    end
                    S_OUTPUT: begin
                        if (bus.disp_ready) begin
                            valid_q   <= 1'b0;
                            grp_q     <= '0;
                            best_sad  <= '1;
                            best_disp <= '0;
                            if (col_q != COL_W'(NUM_COLS - 1)) begin
                                col_q <= col_q + 1'b1;
                                state <= S_SETTLE;
                            end else begin
                                col_q      <= '0;
                                busy_q     <= 1'b0;
                                row_done_q <= 1'b1;
                                state      <= S_IDLE;
                            end
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    assign bus.col_index  = col_q;
    assign bus.group_idx  = grp_q;
    assign bus.busy       = busy_q;
    assign bus.disp_valid = valid_q;
    assign bus.disp_out   = disp_out_q;
    assign bus.disp_cost  = disp_cost_q;
    assign bus.row_done   = row_done_q;
endmodule

// File: tb/tb_disparity_search_ctrl.sv
module tb_disparity_search_ctrl;
    localparam int WIN = 7, DATA_SIZE = 8, IMG_W = 64, MAX_DISP = 32, DT = 8, SAD_LAT = 2;
    localparam int G = 4, NUM_COLS = 27, SB = 14, ALL1 = 16383, NV = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    disparity_search_ctrl_if #(.WIN(WIN), .DATA_SIZE(DATA_SIZE), .IMG_W(IMG_W),
                               .MAX_DISP(MAX_DISP), .DISP_THREADS(DT)) bus ();

    disparity_search_ctrl #(.WIN(WIN), .DATA_SIZE(DATA_SIZE), .IMG_W(IMG_W), .MAX_DISP(MAX_DISP),
                            .DISP_THREADS(DT), .SAD_LAT(SAD_LAT)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // SAD values per (column, disparity) for the row being run.
    int sad_tab [IMG_W][MAX_DISP];
    int exp_d [NUM_COLS];
    int exp_c [NUM_COLS];
    int exp_l [NUM_COLS];
    int exp_g [NUM_COLS];

    // SAD array model: lanes for the driven col/group appear SAD_LAT cycles later.
    function automatic logic [DT*SB-1:0] lanes(input int col, input int grp);
        logic [DT*SB-1:0] v;
        v = '0;
        for (int d = 0; d < DT; d++) v[SB*d +: SB] = SB'(sad_tab[col][grp*DT+d]);
        return v;
    endfunction

    logic [DT*SB-1:0] pipe1, pipe2;
    always @(posedge clk) begin
        pipe1 <= lanes(int'(bus.col_index), int'(bus.group_idx));
        pipe2 <= pipe1;
    end
    assign bus.sad_val = pipe2;

    int hs_count = 0;
    always @(posedge clk) if (bus.disp_valid && bus.disp_ready) hs_count++;

    int n_checks = 0;
    int n_err = 0;
    int cur_col = -1;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s col=%0d: got %0d expected %0d", name, cur_col, act, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, int'(bus.busy), 0);
        chk({tag, "_valid"}, int'(bus.disp_valid), 0);
        chk({tag, "_row_done"}, int'(bus.row_done), 0);
        chk({tag, "_col"}, int'(bus.col_index), 0);
        chk({tag, "_grp"}, int'(bus.group_idx), 0);
        chk({tag, "_disp_out"}, int'(bus.disp_out), 0);
        chk({tag, "_disp_cost"}, int'(bus.disp_cost), 0);
    endtask

    // Directed column patterns and their hand-derived results.
    typedef struct {
        int base;
        int d_a; int v_a;
        int d_b; int v_b;
        int e_disp; int e_cost; int e_lat;
    } vec_t;
    vec_t vecs [NV];

    // Reference: result is the lowest-index argmin over all disparities; the search stops
    // after the first group that contains a zero.
    task automatic model(input int col);
        int best, bd, k;
        best = ALL1; bd = 0;
        for (int i = 0; i < MAX_DISP; i++)
            if (sad_tab[col][i] < best) begin best = sad_tab[col][i]; bd = i; end
        k = (best == 0) ? bd / DT + 1 : G;
        exp_d[col] = bd;
        exp_c[col] = best;
        exp_l[col] = k * (SAD_LAT + 1);
        exp_g[col] = k - 1;
    endtask

    task automatic fill_row(input bit use_table);
        int mode;
        for (int c = 0; c < NUM_COLS; c++) begin
            if (use_table && c < NV) begin
                for (int i = 0; i < MAX_DISP; i++) sad_tab[c][i] = vecs[c].base;
                if (vecs[c].d_a >= 0) sad_tab[c][vecs[c].d_a] = vecs[c].v_a;
                if (vecs[c].d_b >= 0) sad_tab[c][vecs[c].d_b] = vecs[c].v_b;
                exp_d[c] = vecs[c].e_disp;
                exp_c[c] = vecs[c].e_cost;
                exp_l[c] = vecs[c].e_lat;
                exp_g[c] = vecs[c].e_lat / (SAD_LAT + 1) - 1;
            end else begin
                mode = int'($urandom_range(0, 2));
                for (int i = 0; i < MAX_DISP; i++) begin
                    case (mode)
                        0:       sad_tab[c][i] = int'($urandom_range(0, 3));
                        1:       sad_tab[c][i] = int'($urandom_range(0, ALL1));
                        default: sad_tab[c][i] = int'($urandom_range(500, 503));
                    endcase
                end
                if (mode == 2 && $urandom_range(0, 1) == 1)
                    sad_tab[c][$urandom_range(0, MAX_DISP - 1)] = 0;
                model(c);
            end
        end
    endtask

    // stop_kind: 0 none, 1 abort during REDUCE of stop_col, 2 reset mid-SETTLE of stop_col.
    task automatic run_row(input int stall_col, input int stall_len, input int stop_col, input int stop_kind);
        int lat, n;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        chk("busy_on", int'(bus.busy), 1);
        for (int c = 0; c < NUM_COLS; c++) begin
            cur_col = c;
            lat = 0;
            while (bus.disp_valid !== 1'b1) begin
                if (stop_kind != 0 && c == stop_col && lat == (stop_kind == 1 ? 2 : 1)) begin
                    if (stop_kind == 1) begin
                        bus.abort = 1'b1;
                        @(negedge clk);
                        bus.abort = 1'b0;
                        chk("abort_busy", int'(bus.busy), 0);
                        chk("abort_valid", int'(bus.disp_valid), 0);
                        chk("abort_row_done", int'(bus.row_done), 0);
                        chk("abort_col", int'(bus.col_index), 0);
                        chk("abort_grp", int'(bus.group_idx), 0);
                    end else begin
                        #2 rst = 1'b1;
                        #1 chk_all_zero("async_rst");
                        @(negedge clk);
                        rst = 1'b0;
                    end
                    return;
                end
                if (lat > 100) begin
                    chk("latency_timeout", lat, exp_l[c]);
                    return;
                end
                @(negedge clk);
                lat++;
            end
            chk("latency", lat, exp_l[c]);
            chk("disp_out", int'(bus.disp_out), exp_d[c]);
            chk("disp_cost", int'(bus.disp_cost), exp_c[c]);
            chk("col_index", int'(bus.col_index), c);
            chk("group_idx", int'(bus.group_idx), exp_g[c]);
            chk("busy_row", int'(bus.busy), 1);
            n = (c == stall_col) ? stall_len : int'($urandom_range(0, 1));
            for (int i = 0; i < n; i++) begin
                if (c == stall_col) bus.start = 1'b1;  // must be ignored while busy
                @(negedge clk);
                chk("stall_valid", int'(bus.disp_valid), 1);
                chk("stall_disp_out", int'(bus.disp_out), exp_d[c]);
                chk("stall_disp_cost", int'(bus.disp_cost), exp_c[c]);
                chk("stall_col", int'(bus.col_index), c);
                chk("stall_grp", int'(bus.group_idx), exp_g[c]);
            end
            bus.start = 1'b0;
            bus.disp_ready = 1'b1;
            @(negedge clk);
            bus.disp_ready = 1'b0;
            chk("valid_drop", int'(bus.disp_valid), 0);
        end
        cur_col = -1;
        chk("row_done_pulse", int'(bus.row_done), 1);
        chk("busy_off", int'(bus.busy), 0);
        chk("col_back_0", int'(bus.col_index), 0);
        @(negedge clk);
        chk("row_done_single", int'(bus.row_done), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int hs_base;
        vecs[0] = '{100, 19, 5, -1, 0, 19, 5, 12};
        vecs[1] = '{100, 4, 0, -1, 0, 4, 0, 3};
        vecs[2] = '{50, 10, 7, 30, 7, 10, 7, 12};
        vecs[3] = '{50, 1, 7, 5, 7, 1, 7, 12};
        vecs[4] = '{ALL1, -1, 0, -1, 0, 0, ALL1, 12};
        vecs[5] = '{200, 31, 0, -1, 0, 31, 0, 12};
        vecs[6] = '{200, 9, 0, 3, 1, 9, 0, 6};
        vecs[7] = '{300, 0, 0, 8, 0, 0, 0, 3};

        rst = 1'b1;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.disp_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        // Reset dropped in mid-SETTLE of column 2, then a clean full row.
        fill_row(1'b1);
        run_row(-1, 0, 2, 2);
        @(negedge clk);
        fill_row(1'b1);
        hs_base = hs_count;
        run_row(3, 5, -1, 0);
        chk("handshakes_row1", hs_count - hs_base, NUM_COLS);

        // abort in IDLE is a no-op.
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        chk("idle_abort_busy", int'(bus.busy), 0);
        chk("idle_abort_valid", int'(bus.disp_valid), 0);

        // Abort at column 13 during REDUCE; nothing further may come out.
        fill_row(1'b0);
        run_row(-1, 0, 13, 1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("post_abort_quiet", int'({bus.disp_valid, bus.row_done, bus.busy}), 0);
        end

        // Restart after abort begins at column 0 and runs to completion.
        fill_row(1'b0);
        hs_base = hs_count;
        run_row(7, 5, -1, 0);
        chk("handshakes_row2", hs_count - hs_base, NUM_COLS);

        fill_row(1'b0);
        hs_base = hs_count;
        run_row(20, 3, -1, 0);
        chk("handshakes_row3", hs_count - hs_base, NUM_COLS);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
